// File: rtl/fb_pulse_feeder_if.sv
// Event/handshake bundle between local logic, the feeder and the
// pulse synchronizer's source side.
interface fb_pulse_feeder_if #(
  parameter int CNT_W = 4
);
  logic             ev_in;
  logic             busy;
  logic             clr_flags;
  logic             req_out;
  logic [CNT_W-1:0] pending;
  logic             overflow;
  logic             ack_err;
  logic             idle;

  modport master (
    output ev_in, busy, clr_flags,
    input  req_out, pending, overflow, ack_err, idle
  );

  modport slave (
    input  ev_in, busy, clr_flags,
    output req_out, pending, overflow, ack_err, idle
  );
endinterface

// File: rtl/fb_pulse_feeder.sv
// Source-domain feeder: queues event pulses and replays them one at a
// time into the feedback pulse synchronizer, paced by its busy flag.
module fb_pulse_feeder #(
  parameter int CNT_W  = 4,
  parameter int ACK_TO = 8
) (
  input logic              clkA,
  input logic              resetA,
  fb_pulse_feeder_if.slave fb
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_ACK,
    WAIT_DONE
  } state_t;

  localparam logic [CNT_W-1:0] PMAX = '1;
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);
  localparam logic [8:0]      TO_LAST = 9'(ACK_TO - 1);

  state_t           state;
  state_t           stateNxt;
  logic [7:0]       toCnt;
  logic [7:0]       toCntNxt;
  logic [CNT_W-1:0] pend;
  logic [CNT_W-1:0] pendNxt;
  logic             goIssue;
  logic             errSet;
  logic             full;
  logic             inc;
  logic             ovfSet;
  logic             reqQ;
  logic             ovfQ;
  logic             errQ;

  always_comb begin
    stateNxt = state;
    toCntNxt = toCnt;
    goIssue  = 1'b0;
    errSet   = 1'b0;
    unique case (state)
      IDLE: begin
        if (pend != '0 && !fb.busy) begin
          stateNxt = ISSUE;
          goIssue  = 1'b1;
        end
      end
      ISSUE: begin
        stateNxt = WAIT_ACK;
        toCntNxt = '0;
      end
      WAIT_ACK: begin
        if (fb.busy) begin
          stateNxt = WAIT_DONE;
        end else if (({1'b0, toCnt} + 9'd1) >= TO_LAST) begin
          // Give up on this transfer; the event is treated as issued.
          errSet   = 1'b1;
          stateNxt = IDLE;
        end else begin
          toCntNxt = toCnt + 8'd1;
        end
      end
      WAIT_DONE: begin
        if (!fb.busy) stateNxt = IDLE;
      end
      default: stateNxt = IDLE;
    endcase
  end

  // A full queue still accepts when a slot frees up on the same edge.
  always_comb begin
    full    = (pend == PMAX);
    inc     = fb.ev_in && (!full || goIssue);
    ovfSet  = fb.ev_in && full && !goIssue;
    pendNxt = pend;
    if (inc && !goIssue) pendNxt = pend + ONE;
    if (!inc && goIssue) pendNxt = pend - ONE;
  end

  always_ff @(posedge clkA or negedge resetA) begin
    if (!resetA) begin
      state <= IDLE;
      toCnt <= '0;
      pend  <= '0;
      reqQ  <= 1'b0;
      ovfQ  <= 1'b0;
      errQ  <= 1'b0;
    end else begin
      state <= stateNxt;
      toCnt <= toCntNxt;
      pend  <= pendNxt;
      reqQ  <= goIssue;
      ovfQ  <= ovfSet || (ovfQ && !fb.clr_flags);
      errQ  <= errSet || (errQ && !fb.clr_flags);
    end
  end

  assign fb.req_out  = reqQ;
  assign fb.pending  = pend;
  assign fb.overflow = ovfQ;
  assign fb.ack_err  = errQ;
  assign fb.idle     = (state == IDLE) && (pend == '0);

endmodule

// File: tb/tb_fb_pulse_feeder.sv
// Randomized scoreboard bench for fb_pulse_feeder with a transaction-level
// model of the queue, pacing and timeout rules.
module tb_fb_pulse_feeder;

  localparam int CNT_W  = 3;
  localparam int ACK_TO = 4;
  localparam int MAXP   = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic resetA;

  fb_pulse_feeder_if #(.CNT_W(CNT_W)) fb ();

  fb_pulse_feeder #(
    .CNT_W (CNT_W),
    .ACK_TO(ACK_TO)
  ) dut (
    .clkA  (clk),
    .resetA(resetA),
    .fb    (fb)
  );

  always #5 clk = ~clk;

  int nCmp = 0;
  int nBad = 0;
  int cyc  = 0;
  int expQ[$];

  int mPend;
  bit mOvf;
  bit mErr;
  int mAge;
  bit mAcked;

  bit forceBusy = 1'b0;
  bit respEn    = 1'b1;
  int riseCyc   = 0;
  int fallCyc   = 0;

  task automatic chk(input string nm, input int act, input int exp);
    nCmp++;
    if (act != exp) begin
      nBad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Model in terms of "edges since the last issue" rather than states.
  task automatic modelStep(input bit ev, input bit bsy, input bit clr,
                           input bit rstN);
    bit dec;
    bit errSet;
    bit ovfSet;
    int k;
    if (!rstN) begin
      mPend  = 0;
      mOvf   = 0;
      mErr   = 0;
      mAge   = -1;
      mAcked = 0;
      expQ.delete();
      return;
    end
    dec    = 0;
    errSet = 0;
    ovfSet = 0;
    if (mAge < 0) begin
      if (mPend > 0 && !bsy) begin
        dec    = 1;
        mAge   = 0;
        mAcked = 0;
        expQ.push_back(cyc);
      end
    end else begin
      k    = mAge + 1;
      mAge = k;
      if (k >= 2) begin
        if (mAcked) begin
          if (!bsy) mAge = -1;
        end else if (bsy) begin
          mAcked = 1;
        end else if (k >= ACK_TO) begin
          errSet = 1;
          mAge   = -1;
        end
      end
    end
    if (ev) begin
      if (mPend < MAXP || dec) mPend++;
      else ovfSet = 1;
    end
    if (dec) mPend--;
    mOvf = ovfSet || (mOvf && !clr);
    mErr = errSet || (mErr && !clr);
  endtask

  task automatic step(input bit ev, input bit clr);
    bit bBusy;
    bit bRst;
    fb.ev_in     = ev;
    fb.clr_flags = clr;
    fb.busy      = forceBusy || (cyc >= riseCyc && cyc < fallCyc);
    bBusy = fb.busy;
    bRst  = resetA;
    @(posedge clk);
    #1;
    cyc++;
    modelStep(ev, bBusy, clr, bRst);
    chk("pending", int'(fb.pending), mPend);
    chk("overflow", int'(fb.overflow), int'(mOvf));
    chk("ack_err", int'(fb.ack_err), int'(mErr));
    chk("idle", int'(fb.idle), int'(mAge < 0 && mPend == 0));
    if (!bRst) chk("reqInReset", int'(fb.req_out), 0);
    if (respEn && fb.req_out) begin
      riseCyc = cyc + int'($urandom_range(1, 3));
      fallCyc = riseCyc + int'($urandom_range(1, 4));
    end
  endtask

  task automatic drain();
    int n = 0;
    while (!(mAge < 0 && mPend == 0) && n < 300) begin
      step(1'b0, 1'b0);
      n++;
    end
    chk("drainBound", int'(n < 300), 1);
    repeat (6) step(1'b0, 1'b0);
  endtask

  // Scoreboard monitor: every request pulse must match a predicted issue.
  initial begin
    bit prevReq = 1'b0;
    int e;
    forever begin
      @(negedge clk);
      if (fb.req_out) begin
        chk("reqGap", int'(prevReq), 0);
        if (expQ.size() == 0) begin
          chk("reqUnexpected", cyc, -1);
        end else begin
          e = expQ.pop_front();
          chk("reqCycle", cyc, e);
        end
      end
      prevReq = fb.req_out;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    resetA       = 1'b0;
    fb.ev_in     = 1'b0;
    fb.busy      = 1'b0;
    fb.clr_flags = 1'b0;
    modelStep(1'b0, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 5; i++) step(i[0], 1'b0);
    resetA = 1'b1;
    repeat (4) step(1'b0, 1'b0);

    step(1'b1, 1'b0);
    drain();

    forceBusy = 1'b1;
    repeat (5) step(1'b1, 1'b0);
    forceBusy = 1'b0;
    drain();
    repeat (5) step(1'b1, 1'b0);
    drain();

    for (int i = 0; i < 200; i++)
      step($urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0);
    drain();
    step(1'b0, 1'b1);

    forceBusy = 1'b1;
    repeat (MAXP + 3) step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    step(1'b0, 1'b1);
    forceBusy = 1'b0;
    drain();

    respEn = 1'b0;
    step(1'b1, 1'b0);
    repeat (ACK_TO + 4) step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    repeat (ACK_TO + 4) step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    respEn = 1'b1;
    drain();

    forceBusy = 1'b1;
    repeat (MAXP) step(1'b1, 1'b0);
    forceBusy = 1'b0;
    step(1'b1, 1'b0);
    drain();

    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    forceBusy = 1'b1;
    repeat (3) step(1'b1, 1'b0);
    #2;
    resetA = 1'b0;
    #1;
    chk("asyncReq", int'(fb.req_out), 0);
    chk("asyncPending", int'(fb.pending), 0);
    chk("asyncOverflow", int'(fb.overflow), 0);
    chk("asyncAckErr", int'(fb.ack_err), 0);
    chk("asyncIdle", int'(fb.idle), 1);
    modelStep(1'b0, 1'b0, 1'b0, 1'b0);
    forceBusy = 1'b0;
    repeat (3) step(1'b1, 1'b0);
    resetA = 1'b1;
    repeat (4) step(1'b0, 1'b0);

    step(1'b1, 1'b0);
    drain();
    chk("queueEmpty", expQ.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

endmodule
